// File: rtl/dpram_port_arb_pkg.sv
// Shared constants and state encoding for the port-B arbiter of the
// instruction/data dual-port RAM.
package dpram_port_arb_pkg;

    localparam string ARB_RR    = "RR";
    localparam string ARB_FIXED = "FIXED";

    localparam int WEM_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSP  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/dpram_port_arb_if.sv
// One bus master's request/response channel into the port-B arbiter.
interface dpram_port_arb_if
    import dpram_port_arb_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) ();

    logic              req_vld;
    logic              req_rdy;
    logic              we;
    logic [WEM_W-1:0]  wem;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_vld, we, wem, addr, wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rdata
    );

    modport slave (
        input  req_vld, we, wem, addr, wdata, rsp_rdy,
        output req_rdy, rsp_vld, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester arbiter: round-robin on last accepted grant, or fixed
// priority to requester 0 when FIXED is set.
module rr_arb2 #(
    parameter bit FIXED = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // 1 = requester 1 won last, so requester 0 takes the first tie.
    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (FIXED) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) last_d = gnt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/dpram_port_arb.sv
// Shares RAM port B between the core LSU (m0) and the debug/DMA loader (m1),
// tracking the 1-cycle read latency and holding responses under back-pressure.
module dpram_port_arb
    import dpram_port_arb_pkg::*;
#(
    parameter int    ADDR_W   = 11,
    parameter int    DATA_W   = 32,
    parameter string ARB_MODE = ARB_RR
) (
    input  logic               clk,
    input  logic               rst_n,
    dpram_port_arb_if.slave    m0,
    dpram_port_arb_if.slave    m1,
    output logic               ram_en,
    output logic               ram_we,
    output logic [WEM_W-1:0]   ram_wem,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_din,
    input  logic [DATA_W-1:0]  ram_dout
);

    localparam bit FIXED = (ARB_MODE == ARB_FIXED);

    logic [1:0]              req_vld, rsp_rdy, we;
    logic [1:0][WEM_W-1:0]   wem;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0][DATA_W-1:0]  wdata;
    logic [1:0]              gnt, req_rdy, rsp_vld;
    logic [1:0][DATA_W-1:0]  rdata;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                is_wr_q, is_wr_d;
    logic [DATA_W-1:0]   hold_q, hold_d;

    logic                can_acc, accept, owner_rdy, win;
    logic [DATA_W-1:0]   rsp_data;

    assign req_vld = {m1.req_vld, m0.req_vld};
    assign rsp_rdy = {m1.rsp_rdy, m0.rsp_rdy};
    assign we      = {m1.we,      m0.we};
    assign wem     = {m1.wem,     m0.wem};
    assign addr    = {m1.addr,    m0.addr};
    assign wdata   = {m1.wdata,   m0.wdata};

    assign m0.req_rdy = req_rdy[0];
    assign m1.req_rdy = req_rdy[1];
    assign m0.rsp_vld = rsp_vld[0];
    assign m1.rsp_vld = rsp_vld[1];
    assign m0.rdata   = rdata[0];
    assign m1.rdata   = rdata[1];

    assign owner_rdy = rsp_rdy[owner_q];
    assign win       = gnt[1];

    rr_arb2 #(.FIXED(FIXED)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_vld),
        .accept (accept),
        .gnt    (gnt)
    );

    // Acceptance and RAM drive; reset gates req_rdy so all outputs drop at once.
    always_comb begin
        can_acc = 1'b0;
        case (state_q)
            ST_IDLE: can_acc = 1'b1;
            ST_RSP:  can_acc = owner_rdy;
            default: can_acc = 1'b0;
        endcase
        can_acc = can_acc & rst_n;

        req_rdy = gnt & {2{can_acc}};
        accept  = |req_rdy;

        ram_en   = accept;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (accept) begin
            ram_we   = we[win];
            ram_wem  = wem[win];
            ram_addr = addr[win];
            ram_din  = wdata[win];
        end
    end

    // RSP reads straight from the RAM output; HOLD reads the captured copy.
    always_comb begin
        rsp_data = '0;
        if (state_q == ST_HOLD) rsp_data = hold_q;
        else if (!is_wr_q)      rsp_data = ram_dout;

        rsp_vld = 2'b00;
        rdata   = '0;
        if (state_q != ST_IDLE) begin
            rsp_vld[owner_q] = 1'b1;
            rdata[owner_q]   = rsp_data;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        is_wr_d = is_wr_q;
        hold_d  = hold_q;

        if (accept) begin
            owner_d = win;
            is_wr_d = we[win];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RSP;
            end
            ST_RSP: begin
                if (owner_rdy) begin
                    state_d = accept ? ST_RSP : ST_IDLE;
                end else begin
                    hold_d  = rsp_data;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (owner_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            is_wr_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            is_wr_q <= is_wr_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/dpram_port_arb.md
Name: dpram_port_arb

Overview:
- Shares port B of the core's dual-port instruction/data RAM between two bus masters: m0 = core LSU, m1 = debug/DMA loader.
- Port A stays dedicated to instruction fetch and does not pass through this block.
- Arbitrates requests and drives the RAM's enable, write-enable, byte-mask, address and data inputs.
- Tracks the RAM's 1-cycle registered read latency and routes each response to its owner, with back-pressure via a hold register.

Parameters:
- ADDR_W, 11, word-address width (clogb2(RAM_DEPTH-1) for a RAM_DEPTH of 2048).
- DATA_W, 32, data width; only 32 is supported (4 byte lanes).
- ARB_MODE, "RR", arbitration policy: "RR" = two-way round-robin; "FIXED" = m0 always wins.

Ports:
- clk  in  1  single clock; RAM port B uses the same clock.
- rst_n  in  1  asynchronous active-low reset.
- mX_req_vld  in  1  request valid (X = 0, 1; identical sets for both masters).
- mX_req_rdy  out  1  request accepted when vld && rdy.
- mX_we  in  1  1 = write, 0 = read.
- mX_wem  in  4  byte write strobes; ignored for reads.
- mX_addr  in  ADDR_W  word address.
- mX_wdata  in  DATA_W  write data.
- mX_rsp_vld  out  1  response valid.
- mX_rsp_rdy  in  1  master accepts the response.
- mX_rdata  out  DATA_W  read data; 0 for write acks.
- ram_en  out  1  RAM port-B enable.
- ram_we  out  1  RAM port-B write enable.
- ram_wem  out  4  RAM port-B byte strobes.
- ram_addr  out  ADDR_W  RAM port-B address.
- ram_din  out  DATA_W  RAM port-B write data.
- ram_dout  in  DATA_W  RAM port-B read data; valid the cycle after ram_en and held while ram_en=0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all mX_req_rdy and mX_rsp_vld = 0; ram_en = 0; hold register = 0; last_grant = m1, so m0 wins the first RR tie.
- RAM outputs (ram_en, ram_we, ram_wem, ram_addr, ram_din) are combinational from the granted master. With no grant they are all 0.
- ram_en = 1 only in the acceptance cycle; ram_we = granted mX_we.
- Every accepted request, read or write, yields exactly one response. Responses are in order; at most one is outstanding.
- States:
  - IDLE: no response pending. req_rdy goes to the arbitration winner when any vld is high. Acceptance moves to RSP.
  - RSP: the response is presented to its owner, sourced directly from ram_dout (or 0 for a write). owner_rsp_vld = 1.
    - owner rsp_rdy = 1: response completes. The same cycle may accept a new request (1 transaction/cycle throughput). On acceptance stay in RSP, otherwise go to IDLE. req_rdy in this state is combinational on the owner's rsp_rdy.
    - owner rsp_rdy = 0: capture ram_dout (or 0) into the hold register, go to HOLD. No acceptance this cycle.
  - HOLD: response is presented from the hold register; all req_rdy = 0. Owner rsp_rdy = 1 completes the response and goes to IDLE. No acceptance in that cycle, so the RAM data path stays registered.
- Arbitration:
  - RR: if both masters are valid, grant the master != last_grant. last_grant updates only on acceptance.
  - FIXED: m0 wins whenever valid.
  - A single valid master wins in either mode.
- req_rdy is asserted only to the winner, and never depends on the winner's own req_vld beyond selection (no combinational loop).
- Response owner and is_write flag are registered at acceptance. The non-owner's rsp_vld = 0 and its rdata = 0.
- Write with wem = 4'b0000 is still accepted and acked; the RAM changes nothing.
- A read of an address written in the immediately preceding cycle returns the new data (RAM is in NORMAL mode; the write completes before the next read).
- Reset asserted mid-transaction drops any pending response; no rsp_vld after release.
- Address is passed unchanged; no range checking (the bus decoder owns range checking).

Decomposition:
- Shared defines file: ARB_MODE string constants, the 2-bit state encoding (IDLE = 0, RSP = 1, HOLD = 2), and the 4-lane byte-strobe width.
- One sub-module, rr_arb2: a two-request arbiter with a last_grant register, an accept input and a FIXED-mode bypass. It is reused by the later peripheral-bus arbiter.

Test Plan:
- Single read: m0 reads addr 0x010 holding 0xDEADBEEF, rsp_rdy = 1 -> ram_en pulses in cycle N; m0_rsp_vld with rdata = 0xDEADBEEF in N+1.
- Byte write then read: m1 writes 0xAABBCCDD with wem = 4'b0101 to a word preloaded 0x11223344, then reads it back -> write ack rdata = 0; read returns 0x11BB33DD.
- RR contention: both masters hold vld for 4 back-to-back reads, rsp_rdy = 1 -> grants m0, m1, m0, m1 with one acceptance per cycle. FIXED mode -> m0 four times, m1 starved.
- Back-pressure: m0 read with rsp_rdy = 0 for 3 cycles while m1 keeps vld -> HOLD state, rdata stable for 3 cycles, m1_req_rdy = 0 throughout. m1 is granted only the cycle after m0 accepts.
- Reset mid-op: rst_n low while in RSP -> all outputs 0 immediately. After release: IDLE, no stray rsp_vld, and the first RR tie goes to m0.
